// File: rtl/register_file_mw_sb.sv
// ID-stage register file: two async read ports, two sync write ports (port 1 has priority),
// per-register busy scoreboard and raw debug read port. Optional forwarding: WRITE_BYPASS_EN.
module register_file_mw_sb #(
  parameter int RegWidth = 16,
  parameter int AddrBits = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WriteEN0,
  input  logic [AddrBits-1:0] WriteAddr0,
  input  logic [RegWidth-1:0] WriteData0,
  input  logic                WriteEN1,
  input  logic [AddrBits-1:0] WriteAddr1,
  input  logic [RegWidth-1:0] WriteData1,
  input  logic [AddrBits-1:0] ReadAddr1,
  input  logic [AddrBits-1:0] ReadAddr2,
  output logic [RegWidth-1:0] ReadData1,
  output logic [RegWidth-1:0] ReadData2,
  output logic                ReadBusy1,
  output logic                ReadBusy2,
  input  logic                BusyEN,
  input  logic [AddrBits-1:0] BusyAddr,
  input  logic [AddrBits-1:0] inr,
  output logic [RegWidth-1:0] out_value
);

  localparam int Depth = 2 ** AddrBits;

  logic [RegWidth-1:0] r_regs [Depth];
  logic [Depth-1:0]    r_busy;
  logic [Depth-1:0]    w_busy_next;
  logic [RegWidth-1:0] w_data1;
  logic [RegWidth-1:0] w_data2;
  logic                w_busy1;
  logic                w_busy2;

  // Per-register scoreboard: a write-back clears, an issue sets; set is applied last so it wins.
  always_comb begin
    w_busy_next = r_busy;
    for (int a = 0; a < Depth; a++) begin
      if ((WriteEN0 && WriteAddr0 == AddrBits'(a)) || (WriteEN1 && WriteAddr1 == AddrBits'(a)))
        w_busy_next[a] = 1'b0;
      if (BusyEN && BusyAddr == AddrBits'(a))
        w_busy_next[a] = 1'b1;
    end
  end

  // Port 1 write is issued second so it overrides port 0 on an address collision.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < Depth; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (WriteEN0) r_regs[WriteAddr0] <= WriteData0;
      if (WriteEN1) r_regs[WriteAddr1] <= WriteData1;
      r_busy <= w_busy_next;
    end
  end

  always_comb begin
    w_data1 = r_regs[ReadAddr1];
    w_data2 = r_regs[ReadAddr2];
    w_busy1 = r_busy[ReadAddr1];
    w_busy2 = r_busy[ReadAddr2];
`ifdef WRITE_BYPASS_EN
    // Same-cycle forwarding; a forwarded operand is by definition no longer pending.
    if (WriteEN1 && WriteAddr1 == ReadAddr1) begin
      w_data1 = WriteData1;
      w_busy1 = 1'b0;
    end else if (WriteEN0 && WriteAddr0 == ReadAddr1) begin
      w_data1 = WriteData0;
      w_busy1 = 1'b0;
    end
    if (WriteEN1 && WriteAddr1 == ReadAddr2) begin
      w_data2 = WriteData1;
      w_busy2 = 1'b0;
    end else if (WriteEN0 && WriteAddr0 == ReadAddr2) begin
      w_data2 = WriteData0;
      w_busy2 = 1'b0;
    end
`endif
  end

  // Outputs are forced to zero while reset is held so no bypass value leaks out.
  always_comb begin
    ReadData1 = RST_N ? w_data1 : '0;
    ReadData2 = RST_N ? w_data2 : '0;
    ReadBusy1 = RST_N & w_busy1;
    ReadBusy2 = RST_N & w_busy2;
    out_value = RST_N ? r_regs[inr] : '0;
  end

endmodule

// File: tb/tb_register_file_mw_sb.sv
// Bench for register_file_mw_sb: directed scenarios plus random traffic against an array model.
module tb_register_file_mw_sb;
  localparam int W = 16;
  localparam int A = 3;
  localparam int D = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         WriteEN0, WriteEN1, BusyEN;
  logic [A-1:0] WriteAddr0, WriteAddr1, ReadAddr1, ReadAddr2, BusyAddr, inr;
  logic [W-1:0] WriteData0, WriteData1, ReadData1, ReadData2, out_value;
  logic         ReadBusy1, ReadBusy2;

  register_file_mw_sb #(.RegWidth(W), .AddrBits(A)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WriteEN0(WriteEN0), .WriteAddr0(WriteAddr0), .WriteData0(WriteData0),
    .WriteEN1(WriteEN1), .WriteAddr1(WriteAddr1), .WriteData1(WriteData1),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadBusy1(ReadBusy1), .ReadBusy2(ReadBusy2),
    .BusyEN(BusyEN), .BusyAddr(BusyAddr),
    .inr(inr), .out_value(out_value)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model state
  logic [W-1:0] m_regs [D];
  logic [D-1:0] m_busy;
  logic [W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [A-1:0] a);
`ifdef WRITE_BYPASS_EN
    if (WriteEN1 && WriteAddr1 == a) return WriteData1;
    if (WriteEN0 && WriteAddr0 == a) return WriteData0;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_busy_rd(input logic [A-1:0] a);
`ifdef WRITE_BYPASS_EN
    if ((WriteEN1 && WriteAddr1 == a) || (WriteEN0 && WriteAddr0 == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Edge behaviour: port 0 then port 1 (later wins); clears before set (set wins).
  task automatic m_apply();
    if (WriteEN0) begin m_regs[WriteAddr0] = WriteData0; m_busy[WriteAddr0] = 1'b0; end
    if (WriteEN1) begin m_regs[WriteAddr1] = WriteData1; m_busy[WriteAddr1] = 1'b0; end
    if (BusyEN) m_busy[BusyAddr] = 1'b1;
  endtask

  task automatic check_outputs();
    exp_q.push_back(m_read(ReadAddr1));
    exp_q.push_back(m_read(ReadAddr2));
    exp_q.push_back({{(W-1){1'b0}}, m_busy_rd(ReadAddr1)});
    exp_q.push_back({{(W-1){1'b0}}, m_busy_rd(ReadAddr2)});
    exp_q.push_back(m_regs[inr]);
    check_val("rdata1", ReadData1, exp_q.pop_front());
    check_val("rdata2", ReadData2, exp_q.pop_front());
    check_val("rbusy1", {{(W-1){1'b0}}, ReadBusy1}, exp_q.pop_front());
    check_val("rbusy2", {{(W-1){1'b0}}, ReadBusy2}, exp_q.pop_front());
    check_val("out_value", out_value, exp_q.pop_front());
  endtask

  // driver tasks
  task automatic idle(input logic [A-1:0] ra1, input logic [A-1:0] ra2, input logic [A-1:0] ir);
    WriteEN0 = 0; WriteAddr0 = 0; WriteData0 = 0;
    WriteEN1 = 0; WriteAddr1 = 0; WriteData1 = 0;
    BusyEN = 0; BusyAddr = 0;
    ReadAddr1 = ra1; ReadAddr2 = ra2; inr = ir;
  endtask

  task automatic step();
    #2;
    check_outputs();
    @(posedge CLK);
    m_apply();
    @(negedge CLK);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_rd1"}, ReadData1, '0);
    check_val({tag, "_rd2"}, ReadData2, '0);
    check_val({tag, "_bz1"}, {{(W-1){1'b0}}, ReadBusy1}, '0);
    check_val({tag, "_bz2"}, {{(W-1){1'b0}}, ReadBusy2}, '0);
    check_val({tag, "_out"}, out_value, '0);
  endtask

  initial begin
    RST_N = 1'b0;
    idle(1, 2, 3);
    m_reset();
    repeat (2) @(negedge CLK);
    #2;
    check_zero_outputs("in_reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // basic writes on both ports
    idle(0, 0, 0);
    WriteEN0 = 1; WriteAddr0 = 1; WriteData0 = 16'd25;
    WriteEN1 = 1; WriteAddr1 = 2; WriteData1 = 16'd99;
    step();
    idle(0, 0, 0);
    WriteEN0 = 1; WriteAddr0 = 3; WriteData0 = 16'hFFD8;
    step();
    idle(1, 2, 3);
    #2;
    check_val("r1_25", ReadData1, 16'h0019);
    check_val("r2_99", ReadData2, 16'h0063);
    check_val("dbg_r3", out_value, 16'hFFD8);
    step();

    // same-address collision: port 1 wins
    idle(0, 0, 0);
    WriteEN0 = 1; WriteAddr0 = 5; WriteData0 = 16'd7;
    WriteEN1 = 1; WriteAddr1 = 5; WriteData1 = 16'd9;
    step();
    idle(5, 5, 5);
    #2;
    check_val("collide_r5", ReadData1, 16'd9);
    step();

    // scoreboard set / clear / set-wins
    idle(0, 0, 0); BusyEN = 1; BusyAddr = 4;
    step();
    idle(4, 0, 4);
    #2;
    check_val("busy_set", {{(W-1){1'b0}}, ReadBusy1}, 16'd1);
    step();
    idle(0, 0, 0); WriteEN0 = 1; WriteAddr0 = 4; WriteData0 = 16'h1234;
    step();
    idle(4, 0, 4);
    #2;
    check_val("busy_clr", {{(W-1){1'b0}}, ReadBusy1}, 16'd0);
    step();
    idle(0, 0, 0); BusyEN = 1; BusyAddr = 4;
    WriteEN1 = 1; WriteAddr1 = 4; WriteData1 = 16'h1234;
    step();
    idle(4, 0, 4);
    #2;
    check_val("busy_setwins", {{(W-1){1'b0}}, ReadBusy1}, 16'd1);
    check_val("data_setwins", ReadData1, 16'h1234);
    step();

    // forwarding and raw debug port during a write to r6 (r6 left busy beforehand)
    idle(0, 0, 0); BusyEN = 1; BusyAddr = 6;
    WriteEN0 = 1; WriteAddr0 = 6; WriteData0 = 16'h1111;
    step();
    idle(6, 6, 6); WriteEN0 = 1; WriteAddr0 = 6; WriteData0 = 16'hABCD;
    #2;
`ifdef WRITE_BYPASS_EN
    check_val("byp_data", ReadData1, 16'hABCD);
    check_val("byp_busy", {{(W-1){1'b0}}, ReadBusy1}, 16'd0);
`else
    check_val("nobyp_data", ReadData1, 16'h1111);
    check_val("nobyp_busy", {{(W-1){1'b0}}, ReadBusy1}, 16'd1);
`endif
    check_val("dbg_old_r6", out_value, 16'h1111);
    step();
    idle(6, 6, 6);
    #2;
    check_val("after_edge_r6", ReadData1, 16'hABCD);
    step();

    // asynchronous reset asserted mid-cycle, then a write on the first edge after release
    idle(0, 0, 0); BusyEN = 1; BusyAddr = 2;
    step();
    idle(2, 6, 6); WriteEN1 = 1; WriteAddr1 = 2; WriteData1 = 16'h5555;
    #2;
    RST_N = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    m_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(7, 2, 6); WriteEN0 = 1; WriteAddr0 = 7; WriteData0 = 16'h0077;
    step();
    idle(7, 2, 7);
    #2;
    check_val("post_rst_w", ReadData1, 16'h0077);
    check_val("post_rst_r2", ReadData2, 16'h0000);
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      WriteEN0   = 1'($urandom_range(0, 1));
      WriteAddr0 = A'($urandom_range(0, D - 1));
      WriteData0 = W'($urandom);
      WriteEN1   = 1'($urandom_range(0, 1));
      WriteAddr1 = A'($urandom_range(0, D - 1));
      WriteData1 = W'($urandom);
      BusyEN     = 1'($urandom_range(0, 1));
      BusyAddr   = A'($urandom_range(0, D - 1));
      ReadAddr1  = A'($urandom_range(0, D - 1));
      ReadAddr2  = A'($urandom_range(0, D - 1));
      inr        = A'($urandom_range(0, D - 1));
      step();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
